// File: rtl/root_5_en_iter.sv
`default_nettype none
// ============================================================================
// Module      : root_5_en_iter
// Description : Iterative fifth root, res = floor(arg ** (1/5)), found by
//               bit-serial binary search (one result bit per 6 enabled cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module root_5_en_iter #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             arg_vld,
  input  logic [5*W-1:0]   arg,
  output logic             arg_rdy,
  output logic             res_vld,
  output logic [W-1:0]     res,
  output logic             busy
);

  localparam int AW = 5 * W;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SET  = 3'd1,
    S_MUL  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   y_q, y_d;
  logic [AW-1:0]   p_q, p_d;
  logic [W-1:0]    root_q, root_d;
  logic [W-1:0]    cand_q, cand_d;
  logic [IW-1:0]   i_q, i_d;
  logic [1:0]      k_q, k_d;
  logic [W-1:0]    res_q, res_d;
  logic            res_vld_q, res_vld_d;
  logic            busy_q, busy_d;

  logic [W-1:0]    w_bit;
  logic [W-1:0]    w_cand;
  logic [AW-1:0]   w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      p_q       <= '0;
      root_q    <= '0;
      cand_q    <= '0;
      i_q       <= '0;
      k_q       <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      p_q       <= p_d;
      root_q    <= root_d;
      cand_q    <= cand_d;
      i_q       <= i_d;
      k_q       <= k_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    w_bit  = W'(1) << i_q;
    w_cand = root_q | w_bit;
    // Truncation to AW bits is harmless: cand^5 never exceeds 2^(5W)-1.
    w_prod = p_q * {{(AW - W){1'b0}}, cand_q};

    state_d   = state_q;
    y_d       = y_q;
    p_d       = p_q;
    root_d    = root_q;
    cand_d    = cand_q;
    i_d       = i_q;
    k_d       = k_q;
    res_d     = res_q;
    res_vld_d = res_vld_q;
    busy_d    = busy_q;

    if (clk_en) begin
      res_vld_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arg_vld) begin
            y_d     = arg;
            root_d  = '0;
            i_d     = IW'(W - 1);
            busy_d  = 1'b1;
            state_d = S_SET;
          end
        end
        S_SET: begin
          cand_d  = w_cand;
          p_d     = {{(AW - W){1'b0}}, w_cand};
          k_d     = 2'd0;
          state_d = S_MUL;
        end
        S_MUL: begin
          p_d = w_prod;
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = S_CMP;
          end
        end
        S_CMP: begin
          if (p_q <= y_q) begin
            root_d = cand_q;
          end
          if (i_q == '0) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q - IW'(1);
            state_d = S_SET;
          end
        end
        S_DONE: begin
          res_d     = root_q;
          res_vld_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign arg_rdy = (state_q == S_IDLE);
  assign res_vld = res_vld_q;
  assign res     = res_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_root_5_en_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_root_5_en_iter
// Description : Scoreboard bench for root_5_en_iter (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_root_5_en_iter;

  localparam int W  = 8;
  localparam int AW = 5 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b1;
  logic          arg_vld = 1'b0;
  logic [AW-1:0] arg = '0;
  logic          arg_rdy;
  logic          res_vld;
  logic [W-1:0]  res;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  int            en_cnt = 0;
  int            en_ph  = 0;
  bit            en_mode = 1'b0;
  logic [W-1:0]  exp_q[$];

  root_5_en_iter #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .arg_vld (arg_vld),
    .arg     (arg),
    .arg_rdy (arg_rdy),
    .res_vld (res_vld),
    .res     (res),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    en_cnt <= en_cnt + (clk_en ? 1 : 0);
    #1;
    en_ph  = en_ph + 1;
    clk_en = en_mode ? ((en_ph % 3) == 0) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned pow5(input longint unsigned x);
    return x * x * x * x * x;
  endfunction

  function automatic logic [W-1:0] ref_root(input logic [AW-1:0] a);
    for (int r = 255; r > 0; r--) begin
      if (pow5(longint'(r)) <= {24'd0, a}) return W'(r);
    end
    return '0;
  endfunction

  // Each res_vld pulse is consumed by exactly one enabled edge.
  always @(negedge clk) begin
    if (rst_n && res_vld && clk_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_vld", 64'd1, 64'd0);
      end else begin
        check("res", {56'd0, res}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_done();
    int n;
    int acc;
    acc = en_cnt;
    n = 0;
    while (!res_vld && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!res_vld) begin
      check("res_vld_timeout", 64'd0, 64'd1);
    end else begin
      check("latency", 64'(en_cnt - acc), 64'd49);
      if (!clk_en) begin
        @(negedge clk);
        check("res_vld_hold", {63'd0, res_vld}, 64'd1);
      end
    end
  endtask

  task automatic run_req(input logic [AW-1:0] a, input logic [W-1:0] e);
    int n;
    n = 0;
    @(negedge clk);
    while (!(arg_rdy && clk_en) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!(arg_rdy && clk_en)) check("arg_rdy_timeout", 64'd0, 64'd1);
    arg     = a;
    arg_vld = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    arg_vld = 1'b0;
    arg     = {$urandom, $urandom} & {AW{1'b1}};
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done();
  endtask

  initial begin
    logic [AW-1:0] a;
    int n;

    repeat (3) @(negedge clk);
    check("rst_res", {56'd0, res}, 64'd0);
    check("rst_res_vld", {63'd0, res_vld}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_arg_rdy", {63'd0, arg_rdy}, 64'd1);
    rst_n = 1'b1;

    run_req(40'd0, 8'd0);
    run_req(40'd31, 8'd1);
    run_req(40'd32, 8'd2);
    run_req(40'd242, 8'd2);
    run_req(40'd243, 8'd3);
    run_req(40'd1078203909375, 8'd255);
    run_req({AW{1'b1}}, 8'd255);
    a = AW'(pow5(64'd254) - 64'd1);
    run_req(a, 8'd253);

    en_mode = 1'b1;
    run_req(40'd7776, 8'd6);
    en_mode = 1'b0;
    repeat (3) @(negedge clk);

    // arg_vld held high while busy with a wandering arg
    arg = 40'd3125;
    arg_vld = 1'b1;
    exp_q.push_back(8'd5);
    @(negedge clk);
    n = 0;
    while (!arg_rdy && n < 200) begin
      if (n == 10) check("rdy_low_busy", {63'd0, arg_rdy}, 64'd0);
      arg = {$urandom, $urandom} & {AW{1'b1}};
      @(negedge clk);
      n++;
    end
    check("second_wait", {63'd0, arg_rdy}, 64'd1);
    arg = 40'd100000;
    exp_q.push_back(ref_root(40'd100000));
    @(negedge clk);
    arg_vld = 1'b0;
    check("second_accepted", {63'd0, busy}, 64'd1);
    wait_done();

    // reset 20 enabled cycles into a request
    @(negedge clk);
    arg = 40'd59049;
    arg_vld = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_res", {56'd0, res}, 64'd0);
    check("abort_res_vld", {63'd0, res_vld}, 64'd0);
    check("abort_arg_rdy", {63'd0, arg_rdy}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_vld", {63'd0, res_vld}, 64'd0);
    run_req(40'd59049, 8'd9);

    for (int x = 1; x < 256; x++) begin
      a = AW'(pow5(longint'(x)));
      run_req(a, ref_root(a));
      run_req(a - AW'(1), ref_root(a - AW'(1)));
    end
    for (int j = 0; j < 20; j++) begin
      a = {$urandom, $urandom} & {AW{1'b1}};
      run_req(a, ref_root(a));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
`default_nettype wire
